// File: rtl/dcs_gram_attn_core.sv
// ---------------------------------------------------------------------------
// dcs_gram_attn_core
//   Streams an L x N activation matrix X (row-major) and builds the symmetric
//   Gram matrix G = X^T X on the fly. A per-row threshold then produces G'.
//   Next, W_VEC weight vectors of N elements each are streamed in, and the
//   core emits y = G' * w for every vector. G' is reused across all vectors.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   cfg_mode[1:0]     threshold mode, latched on the first X element of a frame
//                     (0/3: pass, 1: keep >= row mean, 2: keep >= row max / 2)
//   i_valid/i_ready/i_data   X element stream
//   w_valid/w_ready/w_data   weight element stream
//   o_valid/o_ready/o_data   result stream, y[0..N-1] per weight vector
//   busy              high in any state other than IDLE
//   done              one-cycle pulse after the last result of the last vector
// ---------------------------------------------------------------------------
module dcs_gram_attn_core #(
  parameter int N     = 8,
  parameter int L     = 16,
  parameter int DW    = 8,
  parameter int W_VEC = 2,
  parameter int OW    = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [1:0]    cfg_mode,
  input  logic          i_valid,
  output logic          i_ready,
  input  logic [DW-1:0] i_data,
  input  logic          w_valid,
  output logic          w_ready,
  input  logic [DW-1:0] w_data,
  output logic          o_valid,
  input  logic          o_ready,
  output logic [OW-1:0] o_data,
  output logic          busy,
  output logic          done
);

  localparam int GW = 2*DW + $clog2(L);            // G entry width, cannot overflow
  localparam int CW = $clog2(N);                   // column / row index width
  localparam int KW = $clog2(L*N);                 // element counter width
  localparam int JW = (W_VEC > 1) ? $clog2(W_VEC) : 1;
  localparam int SW = GW + CW;                     // row-sum width

  if (OW < 3*DW + $clog2(L) + $clog2(N)) begin : g_ow_check
    $error("dcs_gram_attn_core: OW too narrow for the worst-case result");
  end

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_THRESH, S_WGT, S_OUT} state_t;

  state_t               state, state_nxt;
  logic                 armed;          // holds i_ready low while in reset
  logic [1:0]           mode_q;
  logic [KW-1:0]        k_cnt;
  logic [CW-1:0]        wc, rc;
  logic [JW-1:0]        j_cnt;
  logic [DW-1:0]        row_buf [N];
  logic [N-1:0][GW-1:0] g       [N];
  logic [N-1:0][GW-1:0] gp      [N];
  logic [N-1:0][GW-1:0] gp_nxt  [N];
  logic [OW-1:0]        acc     [N];
  logic [2*DW-1:0]      x_prod  [N];
  logic [GW+DW-1:0]     w_prod  [N];

  logic          i_fire, w_fire, o_fire;
  logic [CW-1:0] col;
  logic          last_k, last_r, last_j, frame_end;

  assign i_fire    = i_valid && i_ready;
  assign w_fire    = w_valid && w_ready;
  assign o_fire    = o_valid && o_ready;
  assign col       = k_cnt[CW-1:0];        // N is a power of two, so k % N
  assign last_k    = (k_cnt == KW'(L*N - 1));
  assign last_r    = (rc == CW'(N - 1));
  assign last_j    = (j_cnt == JW'(W_VEC - 1));
  assign frame_end = o_fire && last_r && last_j;

  // Threshold for one row; mode 0/3 yields 0 so nothing is ever zeroed.
  function automatic logic [GW-1:0] row_thr(input logic [1:0] mode,
                                            input logic [N-1:0][GW-1:0] row);
    logic [SW-1:0] sum;
    logic [GW-1:0] mx;
    sum = '0;
    mx  = '0;
    for (int c = 0; c < N; c++) begin
      sum = sum + SW'(row[c]);
      if (row[c] > mx) mx = row[c];
    end
    case (mode)
      2'd1:    row_thr = GW'(sum >> CW);
      2'd2:    row_thr = mx >> 1;
      default: row_thr = '0;
    endcase
  endfunction

  // NOTE: state registers use non-blocking (<=) so every flop samples the
  // values from before the edge; blocking (=) would create ordering races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      armed <= 1'b0;
    end else begin
      state <= state_nxt;
      armed <= 1'b1;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave it unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    i_ready   = 1'b0;
    w_ready   = 1'b0;
    o_valid   = 1'b0;
    o_data    = '0;
    busy      = (state != S_IDLE);
    case (state)
      S_IDLE: begin
        i_ready = armed;
        if (i_fire) state_nxt = S_LOAD;
      end
      S_LOAD: begin
        i_ready = 1'b1;
        if (i_fire && last_k) state_nxt = S_THRESH;
      end
      S_THRESH: state_nxt = S_WGT;
      S_WGT: begin
        w_ready = 1'b1;
        if (w_fire && (wc == CW'(N - 1))) state_nxt = S_OUT;
      end
      S_OUT: begin
        o_valid = 1'b1;
        o_data  = acc[rc];
        if (o_fire && last_r) state_nxt = last_j ? S_IDLE : S_WGT;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // One multiplier per row: the diagonal squares the new element, every
  // other row multiplies it with the buffered element of the same X row.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      x_prod[i] = (CW'(i) == col) ? i_data * i_data : row_buf[i] * i_data;
      w_prod[i] = gp[i][wc] * w_data;
    end
  end

  always_comb begin
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        gp_nxt[r][c] = (g[r][c] < row_thr(mode_q, g[r])) ? '0 : g[r][c];
      end
    end
  end

  // Control counters, mode latch and the row buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= 2'd0;
      k_cnt  <= '0;
      wc     <= '0;
      rc     <= '0;
      j_cnt  <= '0;
      done   <= 1'b0;
      for (int i = 0; i < N; i++) row_buf[i] <= '0;
    end else begin
      done <= frame_end;
      if (i_fire) begin
        if (state == S_IDLE) mode_q <= cfg_mode;
        row_buf[col] <= i_data;
        k_cnt        <= last_k ? '0 : k_cnt + 1'b1;
      end
      if (w_fire) wc <= wc + 1'b1;         // wraps to 0 after N weights
      if (o_fire) begin
        rc <= rc + 1'b1;                   // wraps to 0 after N results
        if (last_r) j_cnt <= last_j ? '0 : j_cnt + 1'b1;
      end
    end
  end

  // Gram accumulation. Column col of the upper triangle (diagonal included)
  // and its mirrored row in the lower triangle are updated together.
  // NOTE: G is a register array, not a RAM, and must start every frame at
  // zero, so it takes the async reset like any other state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) g[i] <= '0;
    end else if (frame_end) begin
      for (int i = 0; i < N; i++) g[i] <= '0;
    end else if (i_fire) begin
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          if ((CW'(j) == col) && (CW'(i) <= col))
            g[i][j] <= g[i][j] + GW'(x_prod[i]);
          else if ((CW'(i) == col) && (CW'(j) < col))
            g[i][j] <= g[i][j] + GW'(x_prod[j]);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) gp[i] <= '0;
    end else if (frame_end) begin
      for (int i = 0; i < N; i++) gp[i] <= '0;
    end else if (state == S_THRESH) begin
      gp <= gp_nxt;
    end
  end

  // Accumulators clear on every entry into WGT (from THRESH or from OUT).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) acc[i] <= '0;
    end else if ((state == S_THRESH) || (o_fire && last_r)) begin
      for (int i = 0; i < N; i++) acc[i] <= '0;
    end else if (w_fire) begin
      for (int i = 0; i < N; i++) acc[i] <= acc[i] + OW'(w_prod[i]);
    end
  end

endmodule
